// File: rtl/l2_mesi_cache_ctrl.sv
// MESI L2 cache controller: tag/state/tree-PLRU arrays, one command at a time,
// shared-bus request handshake, snoop responses, L1 coherence messages and statistics.
module l2_mesi_cache_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 14,
    parameter int WAYS     = 8,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic              bus_req_valid,
    input  logic              bus_req_ready,
    output logic [1:0]        bus_op,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic [1:0]        bus_snoop_in,
    output logic              snoop_result_valid,
    output logic [1:0]        snoop_result,
    output logic              l1_msg_valid,
    output logic              l1_msg,
    output logic [ADDR_W-1:0] l1_msg_addr,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  read_cnt,
    output logic [CNT_W-1:0]  write_cnt
);
    localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
    localparam int WAY_W = $clog2(WAYS);
    localparam int SETS  = 1 << INDEX_W;
    localparam logic [1:0] MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3;
    localparam logic [1:0] SNP_NOHIT = 2'd0, SNP_HIT = 2'd1, SNP_HITM = 2'd2;
    localparam logic [1:0] OP_READ = 2'd0, OP_WRITE = 2'd1, OP_RWIM = 2'd2, OP_INV = 2'd3;
    localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
    localparam logic [WAYS-2:0] ONE_T = (WAYS-1)'(1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, UPG, UPDATE, CLEAR} fsm_t;

    fsm_t state_reg, state_next;
    logic [3:0]         cmd_reg;
    logic [ADDR_W-1:0]  addr_reg, wb_addr_reg;
    logic [WAY_W-1:0]   way_reg;
    logic [1:0]         new_mesi_reg;
    logic               wr_mesi_reg, fill_reg, touch_reg;
    logic [INDEX_W-1:0] clr_idx_reg;

    logic [TAG_W-1:0]   tag_mem  [SETS][WAYS];
    logic [1:0]         mesi_mem [SETS][WAYS];
    logic [WAYS-2:0]    plru_mem [SETS];

    // Tree walk: node n (1-based heap) keeps its bit at n-1; bit 0 steers left.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] tree);
        logic [WAYS-2:0] sh;
        int node;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            sh   = tree >> (node - 1);
            node = 2 * node + (sh[0] ? 1 : 0);
        end
        return WAY_W'(node - WAYS);
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-2:0]  t, mask;
        logic [WAY_W-1:0] wsh;
        int node;
        t    = tree;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            wsh  = way >> (WAY_W - 1 - l);
            mask = ONE_T << (node - 1);
            t    = wsh[0] ? (t & ~mask) : (t | mask);
            node = 2 * node + (wsh[0] ? 1 : 0);
        end
        return t;
    endfunction

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [ADDR_W-1:0]  line_addr, vict_addr;
    logic [WAYS-1:0]    way_hit, way_inv;
    logic               hit, l1_cmd, miss_fill;
    logic [WAY_W-1:0]   hit_way, inv_way, vict_way;
    logic [1:0]         hit_mesi, vict_mesi;

    assign idx       = addr_reg[OFFSET_W +: INDEX_W];
    assign tag       = addr_reg[ADDR_W-1 -: TAG_W];
    assign line_addr = addr_reg & LINE_MASK;
    assign l1_cmd    = (cmd_reg == 4'd0) || (cmd_reg == 4'd1) || (cmd_reg == 4'd2);

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_inv[gi] = (mesi_mem[idx][gi] == MESI_I);
            assign way_hit[gi] = !way_inv[gi] && (tag_mem[idx][gi] == tag);
        end
    endgenerate

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (way_hit[w]) hit_way = WAY_W'(w);
        for (int w = WAYS - 1; w >= 0; w--)
            if (way_inv[w]) inv_way = WAY_W'(w);
        hit       = |way_hit;
        vict_way  = (|way_inv) ? inv_way : plru_victim(plru_mem[idx]);
        hit_mesi  = mesi_mem[idx][hit_way];
        vict_mesi = mesi_mem[idx][vict_way];
        vict_addr = {tag_mem[idx][vict_way], idx, {OFFSET_W{1'b0}}};
        miss_fill = l1_cmd && !hit;
    end

    always_comb begin
        state_next         = state_reg;
        snoop_result_valid = 1'b0;
        snoop_result       = SNP_NOHIT;
        l1_msg_valid       = 1'b0;
        l1_msg             = 1'b0;
        l1_msg_addr        = line_addr;
        case (state_reg)
            IDLE: if (cmd_valid) state_next = LOOKUP;
            LOOKUP: begin
                state_next = UPDATE;
                if (miss_fill) begin
                    if (vict_mesi != MESI_I) begin
                        l1_msg_valid = 1'b1;
                        l1_msg       = 1'b1;
                        l1_msg_addr  = vict_addr;
                    end
                    state_next = (vict_mesi == MESI_M) ? WB : FILL;
                end
                case (cmd_reg)
                    4'd1: if (hit && hit_mesi == MESI_S) state_next = UPG;
                    4'd3: if (hit && hit_mesi == MESI_S) l1_msg_valid = 1'b1;
                    4'd4, 4'd6: begin
                        snoop_result_valid = 1'b1;
                        if (hit) begin
                            snoop_result = (hit_mesi == MESI_M) ? SNP_HITM : SNP_HIT;
                            l1_msg_valid = (cmd_reg == 4'd6);
                            if (hit_mesi == MESI_M) state_next = WB;
                        end
                    end
                    4'd5: snoop_result_valid = 1'b1;
                    4'd8: state_next = CLEAR;
                    default: ;
                endcase
            end
            WB:        if (bus_req_ready) state_next = l1_cmd ? FILL : UPDATE;
            FILL, UPG: if (bus_req_ready) state_next = UPDATE;
            UPDATE:    state_next = IDLE;
            CLEAR:     if (clr_idx_reg == '1) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    assign cmd_ready     = (state_reg == IDLE);
    assign bus_req_valid = (state_reg == WB) || (state_reg == FILL) || (state_reg == UPG);
    assign bus_addr      = (state_reg == WB) ? wb_addr_reg : line_addr;
    always_comb begin
        case (state_reg)
            WB:      bus_op = OP_WRITE;
            FILL:    bus_op = (cmd_reg == 4'd1) ? OP_RWIM : OP_READ;
            UPG:     bus_op = OP_INV;
            default: bus_op = OP_READ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cmd_reg      <= '0;
            addr_reg     <= '0;
            wb_addr_reg  <= '0;
            way_reg      <= '0;
            new_mesi_reg <= MESI_I;
            wr_mesi_reg  <= 1'b0;
            fill_reg     <= 1'b0;
            touch_reg    <= 1'b0;
            clr_idx_reg  <= '0;
            hit_cnt      <= '0;
            read_cnt     <= '0;
            write_cnt    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (cmd_valid) begin
                    cmd_reg  <= cmd;
                    addr_reg <= cmd_addr;
                end
                LOOKUP: begin
                    way_reg      <= miss_fill ? vict_way : hit_way;
                    wb_addr_reg  <= l1_cmd ? vict_addr : line_addr;
                    fill_reg     <= miss_fill;
                    touch_reg    <= l1_cmd;
                    wr_mesi_reg  <= 1'b0;
                    new_mesi_reg <= MESI_M;
                    case (cmd_reg)
                        4'd0, 4'd2: wr_mesi_reg <= !hit;
                        4'd1:       wr_mesi_reg <= 1'b1;
                        4'd3: begin
                            wr_mesi_reg  <= hit && (hit_mesi == MESI_S);
                            new_mesi_reg <= MESI_I;
                        end
                        4'd4: begin
                            wr_mesi_reg  <= hit;
                            new_mesi_reg <= MESI_S;
                        end
                        4'd6: begin
                            wr_mesi_reg  <= hit;
                            new_mesi_reg <= MESI_I;
                        end
                        default: ;
                    endcase
                    if (cmd_reg == 4'd0 || cmd_reg == 4'd2)
                        if (read_cnt != '1) read_cnt <= read_cnt + 1'b1;
                    if (cmd_reg == 4'd1)
                        if (write_cnt != '1) write_cnt <= write_cnt + 1'b1;
                    if (l1_cmd && hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                    if (cmd_reg == 4'd8) begin
                        hit_cnt   <= '0;
                        read_cnt  <= '0;
                        write_cnt <= '0;
                    end
                end
                // Fill state of a read miss depends on whether other caches hold the line.
                FILL: if (bus_req_ready && cmd_reg != 4'd1)
                    new_mesi_reg <= (bus_snoop_in == SNP_NOHIT) ? MESI_E : MESI_S;
                CLEAR: clr_idx_reg <= clr_idx_reg + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                plru_mem[s] <= '0;
                for (int w = 0; w < WAYS; w++) mesi_mem[s][w] <= MESI_I;
            end
        end else if (state_reg == UPDATE) begin
            if (wr_mesi_reg) mesi_mem[idx][way_reg] <= new_mesi_reg;
            if (touch_reg)   plru_mem[idx] <= plru_touch(plru_mem[idx], way_reg);
        end else if (state_reg == CLEAR) begin
            plru_mem[clr_idx_reg] <= '0;
            for (int w = 0; w < WAYS; w++) mesi_mem[clr_idx_reg][w] <= MESI_I;
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == UPDATE && fill_reg) tag_mem[idx][way_reg] <= tag;
    end
endmodule
